bcd_display_scan: RTL
=====================

Name: bcd_display_scan

Overview:
- Downstream consumer of the real-time clock's six BCD digit outputs (HRM, HRL, MIN_M, MIN_L, SEC_M, SEC_L).
- Time-multiplexes the six digits onto one common-anode 7-segment bus with per-digit anode enables.
- Snapshots all six digits once per frame so a clock rollover never shows a torn time.
- Adds anode dead time, optional leading-hour-zero blanking, and separator dots that blink at 1 Hz.

Parameters:
- REFRESH_DIV, 1000: CLK cycles per digit slot. Legal range 2..65535.
- DEAD_CYC, 2: blanked cycles at the start of each slot (anti-ghosting). Legal range 1..REFRESH_DIV-1.
- BLANK_LEAD_ZERO, 1: when 1, blank the HRM digit if its value is 0.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST_N  input  1  synchronous, active-low reset.
- EN  input  1  scan enable.
- HRM, HRL, MIN_M, MIN_L, SEC_M, SEC_L  input  4 each  BCD digits from the clock.
- SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.
- DP  output  1  decimal point, active-low.
- AN  output  6  digit anodes, active-low. AN[0]=SEC_L … AN[5]=HRM.

Behaviour:
- Reset: RST_N=0 sampled on a CLK edge sets:
  - cnt=0, idx=0, snap=24'h000000
  - AN=6'h3F, SEG=7'h7F, DP=1
  - Applies mid-slot and mid-frame alike; takes effect the next edge.
- Slot counter:
  - While EN=1, cnt increments each cycle.
  - At cnt==REFRESH_DIV-1: cnt←0 and idx advances 0→1→…→5→0.
  - While EN=0: cnt and idx hold; scanning resumes at the same position when EN returns.
- Snapshot:
  - snap←{HRM,HRL,MIN_M,MIN_L,SEC_M,SEC_L} on every enabled cycle with cnt==0 and idx==0.
  - This includes the first enabled cycle after reset.
  - Input changes at any other time are ignored until the next frame start.
- Frame length is 6×REFRESH_DIV cycles.
- Outputs are registered, one cycle of latency from (cnt, idx, snap).
- Blank condition: EN==0, or cnt<DEAD_CYC, or (BLANK_LEAD_ZERO==1 and idx==5 and snap HRM==0). When blank:
  - AN=6'h3F, SEG=7'h7F, DP=1.
- Otherwise:
  - AN = all ones except bit idx = 0.
  - SEG = decode(digit[idx]).
  - DP=0 only when idx∈{2,4} and snap SEC_L[0]==0; else DP=1.
- Digit map: idx0 SEC_L, 1 SEC_M, 2 MIN_L, 3 MIN_M, 4 HRL, 5 HRM.
- Decode (hex, active-low): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10.
- Codes A–F decode to 3F (g only, "-").
- Never more than one AN bit low in any cycle.
- No arithmetic overflow: cnt width is ceil(log2(REFRESH_DIV)); idx is 3 bits and wraps explicitly at 5.

Test Plan:
All cases use REFRESH_DIV=4, DEAD_CYC=1, BLANK_LEAD_ZERO=1.

1. Inputs 12:34:56, release reset.
   - Output cycles 1..24, per slot: AN=3F for 1 cycle, then 3 cycles of (AN, SEG).
   - Slots in order: 3E/02, 3D/12, 3B/19, 37/30, 2F/24, 1F/79.
   - DP=0 in slots 2 and 4 (SEC_L=6 is even).
2. Change inputs to 12:34:57 at cycle 10.
   - Remainder of frame still shows 56, DP=0 in slot 4.
   - Next frame shows SEG=78 in slot 0, DP=1 in slots 2/4.
3. Inputs 09:00:00.
   - Slot 5: AN=3F, SEG=7F throughout.
   - Slot 4: AN=2F, SEG=10.
   - Repeat with BLANK_LEAD_ZERO=0: slot 5 shows AN=1F, SEG=40.
4. SEC_L=4'hB.
   - Slot 0: SEG=3F.
   - Other digits unaffected; DP=1 in slots 2/4 (bit0=1).
5. EN=0 for 7 cycles at cnt=2 of slot 3.
   - Outputs blank next cycle, cnt/idx frozen.
   - On EN=1, slot 3 finishes its remaining cycles, then slot 4 starts.
   - Frame length grows by exactly 7 cycles.
6. RST_N=0 for 1 cycle mid-slot 4.
   - Next cycle: AN=3F, SEG=7F, DP=1.
   - Scanning restarts at idx0 with a fresh snapshot.

Source files
------------

// File: rtl/bcd_display_scan.sv
// rtl/bcd_display_scan.sv - six-digit BCD time-multiplexed 7-segment scanner
//
// Ports:
//   CLK                  system clock, rising edge
//   RST_N                synchronous active-low reset
//   EN                   scan enable; when low the scan position freezes and the display blanks
//   HRM, HRL, MIN_M,
//   MIN_L, SEC_M, SEC_L  BCD digits, captured once per frame
//   SEG                  segments {g,f,e,d,c,b,a}, active-low
//   DP                   decimal point, active-low
//   AN                   digit anodes, active-low, AN[0]=SEC_L ... AN[5]=HRM

module bcd_display_scan #(
    parameter int REFRESH_DIV     = 1000,
    parameter int DEAD_CYC        = 2,
    parameter int BLANK_LEAD_ZERO = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic [3:0] HRM,
    input  logic [3:0] HRL,
    input  logic [3:0] MIN_M,
    input  logic [3:0] MIN_L,
    input  logic [3:0] SEC_M,
    input  logic [3:0] SEC_L,
    output logic [6:0] SEG,
    output logic       DP,
    output logic [5:0] AN
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [23:0]   snap;

    logic          slot_end;
    logic          frame_start;
    logic [3:0]    digit;
    logic [6:0]    seg_dec;
    logic          blank;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic [5:0]    an_nxt;

    assign slot_end    = (cnt == CW'(REFRESH_DIV - 1));
    assign frame_start = EN && (cnt == '0) && (idx == 3'd0);

    always_comb begin
        digit = 4'h0;
        case (idx)
            3'd0:    digit = snap[3:0];
            3'd1:    digit = snap[7:4];
            3'd2:    digit = snap[11:8];
            3'd3:    digit = snap[15:12];
            3'd4:    digit = snap[19:16];
            3'd5:    digit = snap[23:20];
            default: digit = 4'h0;
        endcase
    end

    always_comb begin
        seg_dec = 7'h3F;
        case (digit)
            4'd0:    seg_dec = 7'h40;
            4'd1:    seg_dec = 7'h79;
            4'd2:    seg_dec = 7'h24;
            4'd3:    seg_dec = 7'h30;
            4'd4:    seg_dec = 7'h19;
            4'd5:    seg_dec = 7'h12;
            4'd6:    seg_dec = 7'h02;
            4'd7:    seg_dec = 7'h78;
            4'd8:    seg_dec = 7'h00;
            4'd9:    seg_dec = 7'h10;
            default: seg_dec = 7'h3F;  // non-BCD shows a dash
        endcase
    end

    // Dead time at the start of each slot keeps the previous digit's segments
    // from ghosting onto the newly enabled anode.
    always_comb begin
        blank = !EN || (cnt < CW'(DEAD_CYC)) ||
                ((BLANK_LEAD_ZERO == 1) && (idx == 3'd5) && (snap[23:20] == 4'h0));
        an_nxt  = 6'h3F;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        if (!blank) begin
            an_nxt  = 6'h3F & ~(6'b000001 << idx);
            seg_nxt = seg_dec;
            // Separator dots follow the seconds LSB, giving a 1 Hz blink.
            dp_nxt  = !(((idx == 3'd2) || (idx == 3'd4)) && !snap[0]);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt  <= '0;
            idx  <= 3'd0;
            snap <= 24'h000000;
            AN   <= 6'h3F;
            SEG  <= 7'h7F;
            DP   <= 1'b1;
        end else begin
            AN  <= an_nxt;
            SEG <= seg_nxt;
            DP  <= dp_nxt;
            if (frame_start) begin
                snap <= {HRM, HRL, MIN_M, MIN_L, SEC_M, SEC_L};
            end
            if (EN) begin
                if (slot_end) begin
                    cnt <= '0;
                    idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
